// File: rtl/implication_monitor.sv
// -----------------------------------------------------------------------------
// implication_monitor
//
// Hardware run-time checker for the property  ANTE |-> ##DELAY CONS.
// Every accepted antecedent becomes an independent obligation that travels
// down a DELAY-deep shift register; when it reaches the tail it is checked
// against CONS and recorded as a pass or a failure.
//
// Parameters:
//   DELAY      cycles between antecedent and required consequent (1..16)
//   CNT_WIDTH  width of the saturating pass/fail counters
//
// Ports:
//   CLK         clock, all state updates on posedge
//   ASYNCRESET  asynchronous active-high reset, clears everything
//   EN          antecedent sampling enable
//   ANTE        antecedent (upstream stage input)
//   CONS        consequent (upstream stage output)
//   CLR         synchronous clear of counters, sticky flag and pipeline
//   FAIL        registered one-cycle pulse per failed obligation
//   FAILED      sticky failure flag
//   PENDING     at least one obligation outstanding (combinational)
//   PASS_COUNT  saturating count of discharged obligations
//   FAIL_COUNT  saturating count of failed obligations
// -----------------------------------------------------------------------------
module implication_monitor #(
    parameter int DELAY     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 EN,
    input  logic                 ANTE,
    input  logic                 CONS,
    input  logic                 CLR,
    output logic                 FAIL,
    output logic                 FAILED,
    output logic                 PENDING,
    output logic [CNT_WIDTH-1:0] PASS_COUNT,
    output logic [CNT_WIDTH-1:0] FAIL_COUNT
);

    generate
        if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
            $error("implication_monitor: DELAY must be in 1..16");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DELAY-1:0]     sr_q,          sr_d;
    logic                 fail_q,        fail_d;
    logic                 failed_q,      failed_d;
    logic [CNT_WIDTH-1:0] pass_count_q,  pass_count_d;
    logic [CNT_WIDTH-1:0] fail_count_q,  fail_count_d;

    logic tail_s;
    logic chk_pass_s;
    logic chk_fail_s;

    // Obligation due this cycle and its verdict against CONS.
    always_comb begin
        tail_s     = sr_q[DELAY-1];
        chk_pass_s = tail_s & CONS;
        chk_fail_s = tail_s & ~CONS;
    end

    // Next-state: pipeline shift, verdict bookkeeping, CLR override.
    always_comb begin
        sr_d         = {DELAY{1'b0}};
        fail_d       = 1'b0;
        failed_d     = failed_q;
        pass_count_d = pass_count_q;
        fail_count_d = fail_count_q;

        if (CLR) begin
            // Discards the check due now and does not capture ANTE.
            sr_d         = {DELAY{1'b0}};
            fail_d       = 1'b0;
            failed_d     = 1'b0;
            pass_count_d = {CNT_WIDTH{1'b0}};
            fail_count_d = {CNT_WIDTH{1'b0}};
        end else begin
            // The pipeline shifts every cycle; EN only gates new entries.
            sr_d[0] = EN & ANTE;
            for (int k = 1; k < DELAY; k++) begin
                sr_d[k] = sr_q[k-1];
            end

            fail_d = chk_fail_s;

            if (chk_fail_s) begin
                failed_d = 1'b1;
            end else begin
                failed_d = failed_q;
            end

            if (chk_pass_s && (pass_count_q != CNT_MAX)) begin
                pass_count_d = pass_count_q + CNT_ONE;
            end else begin
                pass_count_d = pass_count_q;
            end

            if (chk_fail_s && (fail_count_q != CNT_MAX)) begin
                fail_count_d = fail_count_q + CNT_ONE;
            end else begin
                fail_count_d = fail_count_q;
            end
        end
    end

    // State registers with asynchronous reset; outstanding obligations are dropped.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            sr_q         <= {DELAY{1'b0}};
            fail_q       <= 1'b0;
            failed_q     <= 1'b0;
            pass_count_q <= {CNT_WIDTH{1'b0}};
            fail_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            sr_q         <= sr_d;
            fail_q       <= fail_d;
            failed_q     <= failed_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
        end
    end

    // Output mapping; PENDING is deliberately combinational over the pipeline.
    always_comb begin
        FAIL       = fail_q;
        FAILED     = failed_q;
        PENDING    = |sr_q;
        PASS_COUNT = pass_count_q;
        FAIL_COUNT = fail_count_q;
    end

endmodule

// File: tb/tb_implication_monitor.sv
// -----------------------------------------------------------------------------
// tb_implication_monitor
//
// Four monitor instances with different parameters share one stimulus bus.
// A table of per-cycle records selects which instance is compared and holds
// hand-computed expected outputs after the following clock edge.
// -----------------------------------------------------------------------------
module tb_implication_monitor;

    logic clk;
    logic rst;
    logic en;
    logic ante;
    logic cons;
    logic clr;

    logic       fail_w    [4];
    logic       failed_w  [4];
    logic       pending_w [4];
    logic [7:0] pc_w      [4];
    logic [7:0] fc_w      [4];
    logic [1:0] pc3_s;
    logic [1:0] fc3_s;

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: DELAY=1, u1: DELAY=2, u2: DELAY=3, u3: DELAY=1 CNT_WIDTH=2
    implication_monitor #(.DELAY(1), .CNT_WIDTH(8)) u0 (
        .CLK(clk), .ASYNCRESET(rst), .EN(en), .ANTE(ante), .CONS(cons), .CLR(clr),
        .FAIL(fail_w[0]), .FAILED(failed_w[0]), .PENDING(pending_w[0]),
        .PASS_COUNT(pc_w[0]), .FAIL_COUNT(fc_w[0]));
    implication_monitor #(.DELAY(2), .CNT_WIDTH(8)) u1 (
        .CLK(clk), .ASYNCRESET(rst), .EN(en), .ANTE(ante), .CONS(cons), .CLR(clr),
        .FAIL(fail_w[1]), .FAILED(failed_w[1]), .PENDING(pending_w[1]),
        .PASS_COUNT(pc_w[1]), .FAIL_COUNT(fc_w[1]));
    implication_monitor #(.DELAY(3), .CNT_WIDTH(8)) u2 (
        .CLK(clk), .ASYNCRESET(rst), .EN(en), .ANTE(ante), .CONS(cons), .CLR(clr),
        .FAIL(fail_w[2]), .FAILED(failed_w[2]), .PENDING(pending_w[2]),
        .PASS_COUNT(pc_w[2]), .FAIL_COUNT(fc_w[2]));
    implication_monitor #(.DELAY(1), .CNT_WIDTH(2)) u3 (
        .CLK(clk), .ASYNCRESET(rst), .EN(en), .ANTE(ante), .CONS(cons), .CLR(clr),
        .FAIL(fail_w[3]), .FAILED(failed_w[3]), .PENDING(pending_w[3]),
        .PASS_COUNT(pc3_s), .FAIL_COUNT(fc3_s));

    assign pc_w[3] = {6'b000000, pc3_s};
    assign fc_w[3] = {6'b000000, fc3_s};

    typedef struct packed {
        logic [1:0] sel;
        logic       rst_first;
        logic       en;
        logic       ante;
        logic       cons;
        logic       clr;
        logic       fail;
        logic       failed;
        logic       pending;
        logic [7:0] pc;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int sel, input bit r, input bit e, input bit a,
                       input bit c, input bit cl, input bit f, input bit fd,
                       input bit p, input int pc, input int fc);
        vec_t v;
        v.sel = 2'(sel); v.rst_first = r; v.en = e; v.ante = a; v.cons = c;
        v.clr = cl; v.fail = f; v.failed = fd; v.pending = p;
        v.pc = 8'(pc); v.fc = 8'(fc);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int s, input bit f, input bit fd,
                             input bit p, input int pc, input int fc);
        chk({tag, ".FAIL"},       int'(fail_w[s]),    int'(f));
        chk({tag, ".FAILED"},     int'(failed_w[s]),  int'(fd));
        chk({tag, ".PENDING"},    int'(pending_w[s]), int'(p));
        chk({tag, ".PASS_COUNT"}, int'(pc_w[s]),      pc);
        chk({tag, ".FAIL_COUNT"}, int'(fc_w[s]),      fc);
    endtask

    // Pulse the async reset between clock edges.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input bit e, input bit a, input bit c, input bit cl);
        en = e; ante = a; cons = c; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; en = 1'b0; ante = 1'b0; cons = 1'b0; clr = 1'b0;

        //   sel rst en an co cl | fail fld pend pc fc
        // DELAY=1 pass
        add(0, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0,   0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0);
        // DELAY=1 fail: one-cycle pulse, sticky flag
        add(0, 1, 1, 1, 1, 0,   0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1);
        // DELAY=1 CLR discards the check due in its cycle
        add(0, 1, 1, 1, 1, 0,   0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        // DELAY=3 overlapping obligations, CONS 1,0,1
        add(2, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(2, 0, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(2, 0, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(2, 0, 1, 0, 1, 0,   0, 0, 1, 1, 0);
        add(2, 0, 1, 0, 0, 0,   1, 1, 1, 1, 1);
        add(2, 0, 1, 0, 1, 0,   0, 1, 0, 2, 1);
        // DELAY=2 with EN low: nothing captured
        add(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // DELAY=2 mid-flight CLR
        add(1, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        // CNT_WIDTH=2 fail saturation, then CLR
        add(3, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        add(3, 0, 1, 1, 0, 0,   1, 1, 1, 0, 1);
        add(3, 0, 1, 1, 0, 0,   1, 1, 1, 0, 2);
        add(3, 0, 1, 1, 0, 0,   1, 1, 1, 0, 3);
        add(3, 0, 1, 1, 0, 0,   1, 1, 1, 0, 3);
        add(3, 0, 1, 1, 0, 0,   1, 1, 1, 0, 3);
        add(3, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        // CNT_WIDTH=2 pass saturation
        add(3, 0, 1, 1, 1, 0,   0, 0, 1, 0, 0);
        add(3, 0, 1, 1, 1, 0,   0, 0, 1, 1, 0);
        add(3, 0, 1, 1, 1, 0,   0, 0, 1, 2, 0);
        add(3, 0, 1, 1, 1, 0,   0, 0, 1, 3, 0);
        add(3, 0, 1, 0, 1, 0,   0, 0, 0, 3, 0);

        // Reset state of every instance.
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check_all($sformatf("reset.u%0d", s), s, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) begin
                pulse_reset();
            end
            step(vecs[i].en, vecs[i].ante, vecs[i].cons, vecs[i].clr);
            check_all($sformatf("vec%0d.u%0d", i, vecs[i].sel), int'(vecs[i].sel),
                      vecs[i].fail, vecs[i].failed, vecs[i].pending,
                      int'(vecs[i].pc), int'(vecs[i].fc));
        end

        // DELAY=2: async reset between edges drops the obligation at once.
        pulse_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("ar.pre", 1, 1'b0, 1'b0, 1'b1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("ar.immediate", 1, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("ar.after", 1, 1'b0, 1'b0, 1'b0, 0, 0);

        // DELAY=1: async reset clears a sticky FAILED and counts immediately.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("ar2.failed", 0, 1'b1, 1'b1, 1'b0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all("ar2.immediate", 0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
